mem_wb_stage: RTL and testbench

- MEM/WB pipeline register of the RISC-V core.
- Captures the four writeback candidates (ALU result, aligned load data, PC+4, immediate) plus destination and control. Presents them registered to the downstream 4:1 writeback select mux, which receives them on its ina/inb/inc/ind inputs, with wb_sel on its sel input.
- Handles stall, flush, load byte/half alignment with sign/zero extension, misaligned-load detection, and a retired-instruction counter.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/load_align.sv | 63 ++++++
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//
// Shared definitions for the RISC-V core pipeline:
//   - XLEN_DEFAULT : default datapath width
//   - wb_sel_e     : writeback source select encodings
//                    (WB_ALU / WB_MEM / WB_PC4 / WB_IMM)
//   - F3_*         : load funct3 codes
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Writeback source select, drives the sel input of the 4:1 writeback mux.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//
// Purely combinational load-data aligner. Picks the byte / halfword addressed
// by addr_lo out of the raw memory word and sign- or zero-extends it to XLEN.
// Also reports whether the access is misaligned for its size (the caller
// qualifies this with "is a valid load").
//
// Ports:
//   rdata    in  XLEN  raw data-memory word
//   funct3   in  3     load type (LB/LH/LW/LBU/LHU, others pass raw word)
//   addr_lo  in  2     load address bits [1:0]
//   data     out XLEN  aligned and extended load data
//   misalign out 1     halfword on odd address, or word not on a 4-byte boundary
// -----------------------------------------------------------------------------
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane addr_lo, i.e. bits [8*addr_lo +: 8].
  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];

  // Halfword lane chosen by addr_lo[1] only; addr_lo[0] is the misalign case.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = addr_lo[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        // Unknown load type: pass the raw word through, never flag it.
        data     = rdata;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register. Registers the four writeback candidates (ALU
// result, aligned load data, PC+4, immediate) plus rd / select / control and
// presents them to the downstream 4:1 writeback mux (ina/inb/inc/ind, sel).
// Also keeps a retired-instruction counter.
//
// Update priority on each rising clk edge: reset > flush > stall > capture.
//   flush : bubble; valid, reg_write and misalign cleared, data held,
//           counter held (also when stall is high).
//   stall : everything holds, including the counter.
//
// Configuration macro WB_LOAD_ALIGN_EN:
//   defined   : load byte/half alignment with sign/zero extension and
//               misaligned-load detection (load_align instance).
//   undefined : wb_load is the raw mem_rdata, wb_misalign is always 0 and
//               funct3 / addr_lo are ignored.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   stall, flush           hold / bubble controls
//   in_valid, reg_write    MEM-stage valid and rd write request
//   rd, wb_sel_in          destination register, writeback source select
//   funct3, addr_lo        load type and address bits [1:0]
//   alu_result, mem_rdata,
//   pc_plus4, imm          writeback candidates (XLEN wide)
//   wb_valid, wb_reg_write registered valid, qualified rf write enable
//   wb_rd, wb_sel          registered rd and mux select
//   wb_alu/load/pc4/imm    registered candidates to mux ina/inb/inc/ind
//   wb_misalign            registered misaligned-load flag (no trap here)
//   retire_cnt             retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int RCNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              reg_write,
  input  logic [4:0]        rd,
  input  logic [1:0]        wb_sel_in,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [1:0]        wb_sel,
  output logic [XLEN-1:0]   wb_alu,
  output logic [XLEN-1:0]   wb_load,
  output logic [XLEN-1:0]   wb_pc4,
  output logic [XLEN-1:0]   wb_imm,
  output logic              wb_misalign,
  output logic [RCNT_W-1:0] retire_cnt
);

  // ---------------------------------------------------------------------------
  // Load alignment (optional)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] load_data;
  logic            misalign_now;

`ifdef WB_LOAD_ALIGN_EN
  logic load_misalign;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata    (mem_rdata),
    .funct3   (funct3),
    .addr_lo  (addr_lo),
    .data     (load_data),
    .misalign (load_misalign)
  );

  // Only a valid instruction that actually writes back load data can be a
  // misaligned load; the same funct3/addr_lo on an ALU op means nothing.
  assign misalign_now = in_valid & (wb_sel_in == WB_MEM) & load_misalign;
`else
  logic unused_align_inputs;

  assign load_data           = mem_rdata;
  assign misalign_now        = 1'b0;
  assign unused_align_inputs = ^{funct3, addr_lo};
`endif

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic              valid_q,     valid_d;
  logic              reg_write_q, reg_write_d;
  logic              misalign_q,  misalign_d;
  logic [4:0]        rd_q,        rd_d;
  logic [1:0]        sel_q,       sel_d;
  logic [XLEN-1:0]   alu_q,       alu_d;
  logic [XLEN-1:0]   load_q,      load_d;
  logic [XLEN-1:0]   pc4_q,       pc4_d;
  logic [XLEN-1:0]   imm_q,       imm_d;
  logic [RCNT_W-1:0] cnt_q,       cnt_d;

  // Values loaded on a capture edge.
  always_comb begin
    valid_d     = in_valid;
    // Writes to x0 and misaligned loads never reach the register file.
    reg_write_d = in_valid & reg_write & (rd != 5'd0) & ~misalign_now;
    misalign_d  = misalign_now;
    rd_d        = rd;
    sel_d       = wb_sel_in;
    alu_d       = alu_result;
    load_d      = load_data;
    pc4_d       = pc_plus4;
    imm_d       = imm;
    // Misaligned loads still retire; the counter wraps naturally.
    cnt_d       = in_valid ? cnt_q + RCNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      // Bubble: kill the control bits, leave the data registers alone.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (!stall) begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      misalign_q  <= misalign_d;
      rd_q        <= rd_d;
      sel_q       <= sel_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wb_valid     = valid_q;
  assign wb_reg_write = reg_write_q;
  assign wb_misalign  = misalign_q;
  assign wb_rd        = rd_q;
  assign wb_sel       = sel_q;
  assign wb_alu       = alu_q;
  assign wb_load      = load_q;
  assign wb_pc4       = pc4_q;
  assign wb_imm       = imm_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed, table-driven bench for mem_wb_stage. Expected load data and
// misalign flags depend on whether WB_LOAD_ALIGN_EN is defined for the build.
// A second instance with RCNT_W=4 shares the stimulus to exercise the
// retire-counter wrap.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

`ifdef WB_LOAD_ALIGN_EN
  localparam bit A = 1'b1;
`else
  localparam bit A = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, reg_write;
  logic [4:0]  rd;
  logic [1:0]  wb_sel_in;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu_result, mem_rdata, pc_plus4, imm;

  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu, wb_load, wb_pc4, wb_imm, retire_cnt;

  logic        w4_valid, w4_reg_write, w4_misalign;
  logic [4:0]  w4_rd;
  logic [1:0]  w4_sel;
  logic [31:0] w4_alu, w4_load, w4_pc4, w4_imm;
  logic [3:0]  w4_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .RCNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .reg_write(reg_write), .rd(rd), .wb_sel_in(wb_sel_in),
    .funct3(funct3), .addr_lo(addr_lo), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .imm(imm),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_sel(wb_sel), .wb_alu(wb_alu), .wb_load(wb_load), .wb_pc4(wb_pc4),
    .wb_imm(wb_imm), .wb_misalign(wb_misalign), .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.XLEN(32), .RCNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .reg_write(reg_write), .rd(rd), .wb_sel_in(wb_sel_in),
    .funct3(funct3), .addr_lo(addr_lo), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .imm(imm),
    .wb_valid(w4_valid), .wb_reg_write(w4_reg_write), .wb_rd(w4_rd),
    .wb_sel(w4_sel), .wb_alu(w4_alu), .wb_load(w4_load), .wb_pc4(w4_pc4),
    .wb_imm(w4_imm), .wb_misalign(w4_misalign), .retire_cnt(w4_cnt)
  );

  typedef struct {
    logic        stall, flush, in_valid, reg_write;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] alu, rdata, pc4, imm;
    logic        chk_data, e_valid, e_rw, e_mis;
    logic [4:0]  e_rd;
    logic [1:0]  e_sel;
    logic [31:0] e_alu, e_load, e_pc4, e_imm, e_cnt;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_valid"},     {31'd0, wb_valid},     32'd0);
    chk({tag, ".wb_reg_write"}, {31'd0, wb_reg_write}, 32'd0);
    chk({tag, ".wb_misalign"},  {31'd0, wb_misalign},  32'd0);
    chk({tag, ".wb_rd"},        {27'd0, wb_rd},        32'd0);
    chk({tag, ".wb_sel"},       {30'd0, wb_sel},       32'd0);
    chk({tag, ".wb_alu"},       wb_alu,                32'd0);
    chk({tag, ".wb_load"},      wb_load,               32'd0);
    chk({tag, ".wb_pc4"},       wb_pc4,                32'd0);
    chk({tag, ".wb_imm"},       wb_imm,                32'd0);
    chk({tag, ".retire_cnt"},   retire_cnt,            32'd0);
    chk({tag, ".w4_cnt"},       {28'd0, w4_cnt},       32'd0);
  endtask

  initial begin
    //           stall flush v rw rd     sel    f3      alo    alu           rdata         pc4           imm           chk ev erw emis e_rd   e_sel  e_alu         e_load                                e_pc4         e_imm         e_cnt
    vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,5'd5, 2'b01,3'b000,2'd2,32'h00000011,32'h12F45678,32'h00000104,32'h00001000,1'b1,1'b1,1'b1,1'b0,5'd5, 2'b01,32'h00000011,A ? 32'hFFFFFFF4 : 32'h12F45678,32'h00000104,32'h00001000,32'd1};
    vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,5'd6, 2'b01,3'b100,2'd3,32'h00000022,32'h80FF7F01,32'h00000108,32'h00002000,1'b1,1'b1,1'b1,1'b0,5'd6, 2'b01,32'h00000022,A ? 32'h00000080 : 32'h80FF7F01,32'h00000108,32'h00002000,32'd2};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,5'd7, 2'b01,3'b101,2'd2,32'h00000033,32'hBEEF0000,32'h0000010C,32'h00003000,1'b1,1'b1,1'b1,1'b0,5'd7, 2'b01,32'h00000033,A ? 32'h0000BEEF : 32'hBEEF0000,32'h0000010C,32'h00003000,32'd3};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,5'd8, 2'b01,3'b001,2'd0,32'h00000044,32'h12348001,32'h00000110,32'h00004000,1'b1,1'b1,1'b1,1'b0,5'd8, 2'b01,32'h00000044,A ? 32'hFFFF8001 : 32'h12348001,32'h00000110,32'h00004000,32'd4};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,5'd9, 2'b01,3'b010,2'd1,32'h00000055,32'hCAFEBABE,32'h00000114,32'h00005000,1'b1,1'b1,  !A,   A,5'd9, 2'b01,32'h00000055,32'hCAFEBABE,                     32'h00000114,32'h00005000,32'd5};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,5'd10,2'b01,3'b001,2'd3,32'h00000066,32'h7FFF0000,32'h00000118,32'h00006000,1'b1,1'b1,  !A,   A,5'd10,2'b01,32'h00000066,A ? 32'h00007FFF : 32'h7FFF0000,32'h00000118,32'h00006000,32'd6};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,5'd11,2'b00,3'b010,2'd2,32'h0000DEAD,32'h01020304,32'h0000011C,32'h00007000,1'b1,1'b1,1'b1,1'b0,5'd11,2'b00,32'h0000DEAD,32'h01020304,                     32'h0000011C,32'h00007000,32'd7};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,5'd0, 2'b10,3'b000,2'd0,32'h00000077,32'h00000000,32'h00000120,32'h00008000,1'b1,1'b1,1'b0,1'b0,5'd0, 2'b10,32'h00000077,32'h00000000,                     32'h00000120,32'h00008000,32'd8};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,5'd12,2'b01,3'b010,2'd1,32'h00000088,32'h00000000,32'h00000124,32'h00009000,1'b1,1'b0,1'b0,1'b0,5'd12,2'b01,32'h00000088,32'h00000000,                     32'h00000124,32'h00009000,32'd8};
    vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,5'd3, 2'b00,3'b010,2'd0,32'h000000A5,32'h00000000,32'h00000128,32'h0000A000,1'b1,1'b1,1'b1,1'b0,5'd3, 2'b00,32'h000000A5,32'h00000000,                     32'h00000128,32'h0000A000,32'd9};
    vecs[10] = '{1'b1,1'b0,1'b1,1'b1,5'd4, 2'b01,3'b000,2'd1,32'h00001111,32'hFFFFFFFF,32'h00000200,32'h0000B000,1'b1,1'b1,1'b1,1'b0,5'd3, 2'b00,32'h000000A5,32'h00000000,                     32'h00000128,32'h0000A000,32'd9};
    vecs[11] = '{1'b1,1'b0,1'b1,1'b1,5'd13,2'b11,3'b010,2'd3,32'h00002222,32'h12345678,32'h00000204,32'h0000C000,1'b1,1'b1,1'b1,1'b0,5'd3, 2'b00,32'h000000A5,32'h00000000,                     32'h00000128,32'h0000A000,32'd9};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,5'd14,2'b10,3'b001,2'd1,32'h00003333,32'h87654321,32'h00000208,32'h0000D000,1'b1,1'b1,1'b1,1'b0,5'd3, 2'b00,32'h000000A5,32'h00000000,                     32'h00000128,32'h0000A000,32'd9};
    vecs[13] = '{1'b1,1'b1,1'b1,1'b1,5'd15,2'b00,3'b000,2'd0,32'h00004444,32'h00000000,32'h0000020C,32'h0000E000,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h00000000,32'h00000000,                     32'h00000000,32'h00000000,32'd9};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b1,5'd16,2'b00,3'b000,2'd0,32'h00005555,32'h00000000,32'h00000210,32'h0000F000,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h00000000,32'h00000000,                     32'h00000000,32'h00000000,32'd9};
    vecs[15] = '{1'b0,1'b0,1'b1,1'b1,5'd17,2'b01,3'b011,2'd1,32'h00006666,32'h89ABCDEF,32'h00000130,32'h0000D000,1'b1,1'b1,1'b1,1'b0,5'd17,2'b01,32'h00006666,32'h89ABCDEF,                     32'h00000130,32'h0000D000,32'd10};
    vecs[16] = '{1'b0,1'b0,1'b1,1'b1,5'd18,2'b01,3'b010,2'd2,32'h00007777,32'h0BADF00D,32'h00000134,32'h0000E000,1'b1,1'b1,  !A,   A,5'd18,2'b01,32'h00007777,32'h0BADF00D,                     32'h00000134,32'h0000E000,32'd11};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b1,5'd19,2'b01,3'b010,2'd2,32'h00009999,32'h0BADF00D,32'h00000138,32'h0000E000,1'b0,1'b0,1'b0,1'b0,5'd0, 2'b00,32'h00000000,32'h00000000,                     32'h00000000,32'h00000000,32'd11};
    vecs[18] = '{1'b0,1'b0,1'b1,1'b1,5'd20,2'b11,3'b010,2'd0,32'h00008888,32'h00000000,32'h00000138,32'h0000F000,1'b1,1'b1,1'b1,1'b0,5'd20,2'b11,32'h00008888,32'h00000000,                     32'h00000138,32'h0000F000,32'd12};

    // Reset with random inputs for two edges.
    @(negedge clk);
    rst_n      = 1'b0;
    stall      = 1'($urandom_range(0, 1));
    flush      = 1'($urandom_range(0, 1));
    in_valid   = 1'b1;
    reg_write  = 1'b1;
    rd         = 5'($urandom);
    wb_sel_in  = 2'($urandom);
    funct3     = 3'($urandom);
    addr_lo    = 2'($urandom);
    alu_result = $urandom;
    mem_rdata  = $urandom;
    pc_plus4   = $urandom;
    imm        = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    $display("reset: valid=%0b cnt=%0d", wb_valid, retire_cnt);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      stall      = vecs[i].stall;
      flush      = vecs[i].flush;
      in_valid   = vecs[i].in_valid;
      reg_write  = vecs[i].reg_write;
      rd         = vecs[i].rd;
      wb_sel_in  = vecs[i].sel;
      funct3     = vecs[i].f3;
      addr_lo    = vecs[i].alo;
      alu_result = vecs[i].alu;
      mem_rdata  = vecs[i].rdata;
      pc_plus4   = vecs[i].pc4;
      imm        = vecs[i].imm;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.wb_valid", i),     {31'd0, wb_valid},     {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.wb_reg_write", i), {31'd0, wb_reg_write}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d.wb_misalign", i),  {31'd0, wb_misalign},  {31'd0, vecs[i].e_mis});
      chk($sformatf("v%0d.retire_cnt", i),   retire_cnt,            vecs[i].e_cnt);
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d.wb_rd", i),   {27'd0, wb_rd},  {27'd0, vecs[i].e_rd});
        chk($sformatf("v%0d.wb_sel", i),  {30'd0, wb_sel}, {30'd0, vecs[i].e_sel});
        chk($sformatf("v%0d.wb_alu", i),  wb_alu,  vecs[i].e_alu);
        chk($sformatf("v%0d.wb_load", i), wb_load, vecs[i].e_load);
        chk($sformatf("v%0d.wb_pc4", i),  wb_pc4,  vecs[i].e_pc4);
        chk($sformatf("v%0d.wb_imm", i),  wb_imm,  vecs[i].e_imm);
      end
      $display("vec %0d: stall=%0b flush=%0b valid=%0b rw=%0b rd=%0d sel=%0d alu=%h load=%h mis=%0b cnt=%0d",
               i, stall, flush, wb_valid, wb_reg_write, wb_rd, wb_sel, wb_alu, wb_load, wb_misalign, retire_cnt);
    end

    // The narrow counter saw the same 12 retirements.
    chk("w4_cnt_track", {28'd0, w4_cnt}, 32'd12);

    // Reset asserted while stall and flush are both high: reset wins.
    stall    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid_stall");
    $display("reset mid-stall: valid=%0b cnt=%0d w4_cnt=%0d", wb_valid, retire_cnt, w4_cnt);
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;

    // Counter wrap on the RCNT_W=4 instance: 16 valid captures.
    in_valid  = 1'b1;
    reg_write = 1'b1;
    rd        = 5'd1;
    wb_sel_in = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) chk("wrap_pre", {28'd0, w4_cnt}, 32'd15);
      if (k == 16) begin
        chk("wrap_w4_cnt", {28'd0, w4_cnt}, 32'd0);
        chk("wrap_cnt32",  retire_cnt,      32'd16);
      end
    end
    $display("wrap: w4_cnt=%0d cnt=%0d", w4_cnt, retire_cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
